vga_sprite_overlay: RTL
=======================

// Module: vga_sprite_overlay
// PURPOSE
// - Hardware cursor/sprite generator between vga_control and bitgen: compares hcount/vcount with a
//   16x16 1bpp sprite and drives bitgen's pixel_en/fg_pixel; framebuffer pixel becomes bg_pixel.
// - CPU-side config port writes bitmap, position, colour, enable; position/colour/enable are shadowed
//   and committed only at frame boundary, so the sprite never tears mid-frame.
// PARAMETERS
// - H_ACTIVE    640  visible columns; hcount >= H_ACTIVE never hits
// - V_ACTIVE    480  visible rows; commit tick fires at hcount==0 && vcount==V_ACTIVE
// - PIPE_STAGES 2    output delay (cycles) matching address_generator pixel latency; legal 1..4
// PORTS
// - clk         in   1   system clock
// - rst         in   1   asynchronous, active-high reset
// - hcount      in   10  current column from vga_control
// - vcount      in   10  current row from vga_control
// - cfg_we      in   1   write strobe, one word per cycle, no backpressure
// - cfg_addr    in   5   0x00-0x0F bitmap rows 0-15; 0x10 X; 0x11 Y; 0x12 colour[15:0];
//                        0x13 colour[23:16] (wdata[7:0]); 0x14 ctrl (bit0 enable); others ignored
// - cfg_wdata   in   16  write data; X/Y use [9:0]
// - pixel_en    out  1   sprite pixel opaque at delayed position
// - fg_pixel    out  24  sprite colour when pixel_en, else 24'h000000
// - cfg_pending out  1   shadow regs hold values not yet committed
// BEHAVIOUR
// - Reset: pixel_en=0, fg_pixel=0, cfg_pending=0; shadow+active X=Y=0, colour=24'hFFFFFF,
//   enable=0; bitmap rows all 0; delay pipeline cleared.
// - Writes: registered on the cfg_we cycle. Bitmap rows write straight to live bitmap (no shadow).
//   Writes to 0x10-0x14 update shadow and set cfg_pending on the next edge.
// - Commit: on frame tick (hcount==0 && vcount==V_ACTIVE, one cycle, first cycle of vblank)
//   active<=shadow, cfg_pending<=0. Write on same cycle as tick: active takes pre-write shadow,
//   write lands in shadow, cfg_pending stays 1. Tick is level-detected on hcount/vcount; if
//   vcount dwells at that value >1 cycle commit repeats harmlessly (idempotent).
// - Hit (stage 0, combinational on inputs): dx={1'b0,hcount}-{1'b0,X}, dy likewise, 11-bit;
//   hit = enable && !dx[10] && dx<16 && !dy[10] && dy<16 && hcount<H_ACTIVE && vcount<V_ACTIVE.
//   No wrap: sprite at X=630 shows cols 630-639 only; X>=H_ACTIVE or Y>=V_ACTIVE never visible.
// - Pixel bit = bitmap[dy[3:0]][15-dx[3:0]] (bit15 leftmost).
// - Pipeline: {hit&&bit, colour} pass through PIPE_STAGES registers; outputs are last stage, so
//   pixel_en for (h,v) appears PIPE_STAGES edges after hcount/vcount show (h,v).
// - Colour sampled with hit at stage 0 (active colour, stable within a frame).
// - Reset mid-frame: async clear of all state; outputs 0 immediately; config lost.
// STRUCTURE
// - vga_pkg: H_ACTIVE/V_ACTIVE defaults, SPR_SIZE=16, register-address constants
//   (REG_X, REG_Y, REG_COL_LO, REG_COL_HI, REG_CTRL).
// - One sub-module vga_sprite_regs: bitmap array, shadow/active regs, commit, cfg_pending.
//   Top keeps hit compare, bitmap lookup, delay pipeline. Top-level vga instantiates this
//   and ties pixel_en/fg_pixel into bitgen, framebuffer pixel to bg_pixel.
// TESTING
// - Reset then sweep full frame with enable=0 -> pixel_en never 1, fg_pixel==0, cfg_pending==0.
// - Rows 0-15=16'h8001, X=100, Y=50, colour=24'hFF0000, enable=1, run to tick -> cfg_pending
//   1->0 at tick; next frame pixel_en only at (100,50..65),(115,50..65), 2 cycles after hcount.
// - X=630,Y=470, row all 16'hFFFF -> hits only cols 630-639, rows 470-479; no hit at col 0 or row 0.
// - Write X=200 mid-frame (vcount=100) -> rest of frame uses old X; new X after tick.
// - Write X=300 on exact tick cycle -> committed X stays old, cfg_pending=1; commits next frame.
// - Assert rst mid-frame during an active hit -> pixel_en/fg_pixel 0 same cycle; enable=0 after.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA hardware sprite/cursor overlay.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int SPR_SIZE     = 16;

    localparam logic [4:0] REG_X      = 5'h10;
    localparam logic [4:0] REG_Y      = 5'h11;
    localparam logic [4:0] REG_COL_LO = 5'h12;
    localparam logic [4:0] REG_COL_HI = 5'h13;
    localparam logic [4:0] REG_CTRL   = 5'h14;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] colour;
        logic        enable;
    } spr_cfg_t;

    localparam spr_cfg_t SPR_CFG_RST = '{x: 10'd0, y: 10'd0, colour: 24'hFFFFFF, enable: 1'b0};

    typedef struct packed {
        logic        en;
        logic [23:0] colour;
    } pix_t;

    function automatic logic is_cfg_reg(input logic [4:0] addr);
        return (addr >= REG_X) && (addr <= REG_CTRL);
    endfunction

endpackage

// File: rtl/vga_sprite_overlay_if.sv
// CPU-side configuration port of the sprite overlay: one write per cycle, no backpressure.
interface vga_sprite_overlay_if;

    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_pending;

    modport master (output cfg_we, cfg_addr, cfg_wdata, input cfg_pending);
    modport slave  (input cfg_we, cfg_addr, cfg_wdata, output cfg_pending);

endinterface

// File: rtl/vga_sprite_regs.sv
// Sprite register file: live bitmap, shadowed position/colour/enable, frame-boundary commit.
module vga_sprite_regs
    import vga_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    vga_sprite_overlay_if.slave  cfg,
    input  logic                 commit,
    input  logic [3:0]           row_sel,
    output logic [15:0]          row_bits,
    output spr_cfg_t             active
);

    logic [15:0] bitmap_q [SPR_SIZE];
    logic [15:0] bitmap_d [SPR_SIZE];
    spr_cfg_t    shadow_q, shadow_d;
    spr_cfg_t    active_q, active_d;
    logic        pending_q, pending_d;

    always_comb begin
        // NOTE: every _d starts from its _q so each path assigns it; no latch can be inferred.
        bitmap_d  = bitmap_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;

        // Commit first so a write on the tick cycle stays pending for the next frame.
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        if (cfg.cfg_we) begin
            if (!cfg.cfg_addr[4]) begin
                bitmap_d[cfg.cfg_addr[3:0]] = cfg.cfg_wdata;
            end
            case (cfg.cfg_addr)
                REG_X:      shadow_d.x             = cfg.cfg_wdata[9:0];
                REG_Y:      shadow_d.y             = cfg.cfg_wdata[9:0];
                REG_COL_LO: shadow_d.colour[15:0]  = cfg.cfg_wdata;
                REG_COL_HI: shadow_d.colour[23:16] = cfg.cfg_wdata[7:0];
                REG_CTRL:   shadow_d.enable        = cfg.cfg_wdata[0];
                default:    ;
            endcase
            if (is_cfg_reg(cfg.cfg_addr)) begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the bitmap array is reset too, so a freshly reset sprite is blank rather than garbage.
            for (int i = 0; i < SPR_SIZE; i++) begin
                bitmap_q[i] <= '0;
            end
            shadow_q  <= SPR_CFG_RST;
            active_q  <= SPR_CFG_RST;
            pending_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            bitmap_q  <= bitmap_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign row_bits        = bitmap_q[row_sel];
    assign active          = active_q;
    assign cfg.cfg_pending = pending_q;

endmodule

// File: rtl/vga_sprite_overlay.sv
// 16x16 1bpp hardware sprite overlay: hit test on hcount/vcount, bitmap lookup, latency-matched output.
module vga_sprite_overlay
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int PIPE_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           hcount,
    input  logic [9:0]           vcount,
    vga_sprite_overlay_if.slave  cfg,
    output logic                 pixel_en,
    output logic [23:0]          fg_pixel
);

    spr_cfg_t    active;
    logic [15:0] row_bits;
    logic        commit;
    logic [10:0] dx, dy;
    logic        hit;
    logic        pix_bit;
    pix_t        stage0;
    pix_t        pipe_q [PIPE_STAGES];
    pix_t        pipe_d [PIPE_STAGES];

    // First cycle of vertical blanking.
    assign commit = (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));

    vga_sprite_regs u_regs (
        .clk      (clk),
        .rst      (rst),
        .cfg      (cfg),
        .commit   (commit),
        .row_sel  (dy[3:0]),
        .row_bits (row_bits),
        .active   (active)
    );

    // 11-bit differences: bit 10 set means the beam is left of / above the sprite.
    assign dx = {1'b0, hcount} - {1'b0, active.x};
    assign dy = {1'b0, vcount} - {1'b0, active.y};

    assign hit = active.enable
              && !dx[10] && (dx < 11'(SPR_SIZE))
              && !dy[10] && (dy < 11'(SPR_SIZE))
              && (hcount < 10'(H_ACTIVE))
              && (vcount < 10'(V_ACTIVE));

    // Bit 15 is the leftmost pixel, and 15-n equals ~n on four bits.
    assign pix_bit = row_bits[~dx[3:0]];

    always_comb begin
        stage0.en     = hit && pix_bit;
        stage0.colour = stage0.en ? active.colour : 24'h000000;
    end

    always_comb begin
        pipe_d[0] = stage0;
        for (int i = 1; i < PIPE_STAGES; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign pixel_en = pipe_q[PIPE_STAGES-1].en;
    assign fg_pixel = pipe_q[PIPE_STAGES-1].colour;

endmodule
